// File: rtl/dm_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
// RV32I load/store encodings, FSM state type and timeout counter width.
package dm_access_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int TMO_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/store_align.sv
// Store lane steering and access-fault detection.
// Purely combinational; no state, no backpressure.
module store_align
    import dm_access_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic        i_read,
    input  logic        i_write,
    output logic [3:0]  o_we,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    output logic        o_illegal
);

    logic w_f3_ok;

    always_comb begin
        o_we    = 4'b0000;
        o_wdata = i_wdata;
        w_f3_ok = 1'b0;
        if (i_write) begin
            case (i_funct3)
                SB: begin
                    w_f3_ok = 1'b1;
                    o_we    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                SH: begin
                    w_f3_ok = 1'b1;
                    o_we    = 4'b0011 << {i_addr_lo[1], 1'b0};
                    o_wdata = {2{i_wdata[15:0]}};
                end
                SW: begin
                    w_f3_ok = 1'b1;
                    o_we    = 4'b1111;
                end
                default: w_f3_ok = 1'b0;
            endcase
        end else if (i_read) begin
            case (i_funct3)
                LB, LH, LW, LBU, LHU: w_f3_ok = 1'b1;
                default:              w_f3_ok = 1'b0;
            endcase
        end
    end

    // funct3[1:0] encodes access size for both loads and stores
    assign o_misaligned = (i_read | i_write) &
                          (((i_funct3[1:0] == 2'b10) & (i_addr_lo != 2'b00)) |
                           ((i_funct3[1:0] == 2'b01) & i_addr_lo[0]));

    assign o_illegal = (i_read & i_write) | ((i_read | i_write) & ~w_f3_ok);

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory access controller: request/ack handshake, ack timeout, MEM/WB register.
// Accept at T, dm_req at T+1, wb_valid one cycle after ack; stall held while an access is outstanding.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic        wb_memread,
    output logic [31:0] wb_rdata,
    output logic [2:0]  wb_funct3,
    output logic [1:0]  wb_addr_lo,
    output logic        wb_err
);

    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(ACK_TIMEOUT - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [TMO_CNT_W-1:0]   r_cnt;
    logic                   r_is_load;
    logic [2:0]             r_funct3;
    logic [1:0]             r_addr_lo;

    logic                   w_op;
    logic                   w_fault;
    logic                   w_accept;
    logic                   w_timeout_hit;
    logic                   w_complete;
    logic                   w_stall;
    logic [3:0]             w_we;
    logic [31:0]            w_wdata;
    logic                   w_misaligned;
    logic                   w_illegal;

    store_align u_store_align (
        .i_funct3     (req_funct3),
        .i_addr_lo    (req_addr[1:0]),
        .i_wdata      (req_wdata),
        .i_read       (req_read),
        .i_write      (req_write),
        .o_we         (w_we),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    assign w_op          = req_valid & (req_read | req_write);
    assign w_fault       = w_op & (w_misaligned | w_illegal);
    assign w_accept      = (r_state == IDLE) & w_op & ~w_fault;
    assign w_timeout_hit = (r_state == WAIT) & (r_cnt == TMO_LAST) & ~dm_ack;
    assign w_complete    = (r_state == WAIT) & (dm_ack | w_timeout_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_op && !w_fault) begin
                    w_stall      = 1'b1;
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                w_stall = ~dm_ack & ~w_timeout_hit;
                if (dm_ack || w_timeout_hit) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Reset forces stall low even if a valid request is presented
    assign stall = w_stall & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_req    <= 1'b0;
            dm_we     <= 4'b0000;
            dm_addr   <= 32'h0;
            dm_wdata  <= 32'h0;
            r_is_load <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_cnt     <= '0;
        end else if (w_accept) begin
            dm_req    <= 1'b1;
            dm_we     <= w_we;
            dm_addr   <= {req_addr[31:2], 2'b00};
            dm_wdata  <= w_wdata;
            r_is_load <= req_read;
            r_funct3  <= req_funct3;
            r_addr_lo <= req_addr[1:0];
            r_cnt     <= '0;
        end else if (w_complete) begin
            dm_req <= 1'b0;
            dm_we  <= 4'b0000;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_memread <= 1'b0;
            wb_rdata   <= 32'h0;
            wb_funct3  <= 3'b000;
            wb_addr_lo <= 2'b00;
            wb_err     <= 1'b0;
        end else if (!w_stall) begin
            if (r_state == WAIT) begin
                // Unstalled in WAIT means either ack or timeout this cycle
                wb_valid   <= 1'b1;
                wb_memread <= r_is_load & dm_ack;
                wb_rdata   <= (r_is_load & dm_ack) ? dm_rdata : 32'h0;
                wb_funct3  <= r_funct3;
                wb_addr_lo <= r_addr_lo;
                wb_err     <= w_timeout_hit;
            end else begin
                wb_valid   <= req_valid;
                wb_memread <= 1'b0;
                wb_rdata   <= 32'h0;
                wb_funct3  <= req_funct3;
                wb_addr_lo <= req_addr[1:0];
                wb_err     <= w_fault;
            end
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a 4-cycle ack timeout.
module tb_dm_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_read;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        wb_valid;
    logic        wb_memread;
    logic [31:0] wb_rdata;
    logic [2:0]  wb_funct3;
    logic [1:0]  wb_addr_lo;
    logic        wb_err;

    int n_checks = 0;
    int n_errors = 0;

    dm_access_ctrl #(.ACK_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_ack     (dm_ack),
        .dm_rdata   (dm_rdata),
        .wb_valid   (wb_valid),
        .wb_memread (wb_memread),
        .wb_rdata   (wb_rdata),
        .wb_funct3  (wb_funct3),
        .wb_addr_lo (wb_addr_lo),
        .wb_err     (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = v;
        req_read   = rd;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    initial begin
        rst_n    = 1'b0;
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        // legal load presented during reset must not raise stall
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        @(negedge clk);
        chk("rst_stall",    stall,    0);
        chk("rst_dm_req",   dm_req,   0);
        chk("rst_dm_we",    dm_we,    0);
        chk("rst_dm_addr",  dm_addr,  0);
        chk("rst_dm_wdata", dm_wdata, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_err",   wb_err,   0);
        next_cycle();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        next_cycle();

        // SB to 0x1003, zero-wait ack
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5);
        @(negedge clk);
        chk("sb_accept_stall", stall,  1);
        chk("sb_accept_req",   dm_req, 0);
        next_cycle();
        dm_ack = 1'b1;
        @(negedge clk);
        chk("sb_dm_req",   dm_req,   1);
        chk("sb_dm_we",    dm_we,    4'b1000);
        chk("sb_dm_wdata", dm_wdata, 32'hA5A5_A5A5);
        chk("sb_dm_addr",  dm_addr,  32'h0000_1000);
        chk("sb_ack_stall", stall,   0);
        next_cycle();

        // LHU to 0x2002 immediately after, ack after 3 wait cycles
        dm_ack = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0);
        @(negedge clk);
        chk("sb_wb_valid",   wb_valid,   1);
        chk("sb_wb_err",     wb_err,     0);
        chk("sb_wb_memread", wb_memread, 0);
        chk("sb_done_req",   dm_req,     0);
        chk("lhu_stall0",    stall,      1);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            @(negedge clk);
            chk("lhu_wait_stall", stall,    1);
            chk("lhu_wait_req",   dm_req,   1);
            chk("lhu_wait_we",    dm_we,    0);
            chk("lhu_wait_addr",  dm_addr,  32'h0000_2000);
            chk("lhu_wb_hold",    wb_valid, 1);
        end
        next_cycle();
        dm_ack   = 1'b1;
        dm_rdata = 32'hBEEF_1234;
        @(negedge clk);
        chk("lhu_ack_stall", stall, 0);
        next_cycle();

        // misaligned LW presented right after LHU completes
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'h0);
        @(negedge clk);
        chk("lhu_wb_valid",   wb_valid,   1);
        chk("lhu_wb_memread", wb_memread, 1);
        chk("lhu_wb_rdata",   wb_rdata,   32'hBEEF_1234);
        chk("lhu_wb_addr_lo", wb_addr_lo, 2'b10);
        chk("lhu_wb_funct3",  wb_funct3,  3'b101);
        chk("lhu_wb_err",     wb_err,     0);
        chk("lhu_done_req",   dm_req,     0);
        chk("lwmis_stall",    stall,      0);
        next_cycle();

        // illegal load funct3 011
        drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0);
        @(negedge clk);
        chk("lwmis_wb_valid",   wb_valid,   1);
        chk("lwmis_wb_err",     wb_err,     1);
        chk("lwmis_wb_memread", wb_memread, 0);
        chk("lwmis_no_req",     dm_req,     0);
        chk("ill_stall",        stall,      0);
        next_cycle();

        // misaligned SH
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h0000_1234);
        @(negedge clk);
        chk("ill_wb_valid", wb_valid, 1);
        chk("ill_wb_err",   wb_err,   1);
        chk("ill_no_req",   dm_req,   0);
        chk("shmis_stall",  stall,    0);
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("shmis_wb_err", wb_err, 1);
        chk("shmis_no_req", dm_req, 0);
        next_cycle();

        // bubble clears the MEM/WB slot
        @(negedge clk);
        chk("bubble_wb_valid", wb_valid, 0);
        chk("bubble_wb_err",   wb_err,   0);

        // legal SH to upper half
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_CAFE);
        next_cycle();
        dm_ack = 1'b1;
        @(negedge clk);
        chk("sh_dm_we",    dm_we,    4'b1100);
        chk("sh_dm_wdata", dm_wdata, 32'hCAFE_CAFE);
        chk("sh_dm_addr",  dm_addr,  32'h0000_0100);
        next_cycle();
        dm_ack = 1'b0;

        // SW with no ack: timeout after 4 WAIT cycles
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_to_stall0", stall, 1);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            chk("sw_to_req", dm_req, 1);
            chk("sw_to_stall", stall, (i < 3) ? 1 : 0);
            if (i == 0) begin
                chk("sw_to_we",    dm_we,    4'b1111);
                chk("sw_to_wdata", dm_wdata, 32'hDEAD_BEEF);
            end
        end
        next_cycle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("sw_to_req_drop",   dm_req,     0);
        chk("sw_to_wb_valid",   wb_valid,   1);
        chk("sw_to_wb_err",     wb_err,     1);
        chk("sw_to_wb_memread", wb_memread, 0);
        chk("sw_to_wb_rdata",   wb_rdata,   0);
        next_cycle();
        dm_ack = 1'b1;
        @(negedge clk);
        chk("sw_to_idle_wb", wb_valid, 0);
        next_cycle();
        @(negedge clk);
        chk("idle_ack_ignored", wb_valid, 0);
        chk("idle_ack_noreq",   dm_req,   0);
        dm_ack = 1'b0;
        next_cycle();

        // back-to-back LW 0x10 then SW 0x14
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0);
        @(negedge clk);
        chk("b2b_lw_stall", stall,  1);
        chk("b2b_lw_noreq", dm_req, 0);
        next_cycle();
        dm_ack   = 1'b1;
        dm_rdata = 32'h1111_2222;
        @(negedge clk);
        chk("b2b_lw_req",   dm_req,  1);
        chk("b2b_lw_we",    dm_we,   0);
        chk("b2b_lw_addr",  dm_addr, 32'h0000_0010);
        chk("b2b_lw_ackst", stall,   0);
        next_cycle();
        dm_ack   = 1'b0;
        dm_rdata = 32'h0;
        drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h5566_7788);
        @(negedge clk);
        chk("b2b_gap_req",     dm_req,     0);
        chk("b2b_sw_stall",    stall,      1);
        chk("b2b_lw_wb_valid", wb_valid,   1);
        chk("b2b_lw_wb_mr",    wb_memread, 1);
        chk("b2b_lw_wb_rdata", wb_rdata,   32'h1111_2222);
        next_cycle();
        dm_ack = 1'b1;
        @(negedge clk);
        chk("b2b_sw_req",   dm_req,     1);
        chk("b2b_sw_we",    dm_we,      4'b1111);
        chk("b2b_sw_addr",  dm_addr,    32'h0000_0014);
        chk("b2b_sw_wdata", dm_wdata,   32'h5566_7788);
        chk("b2b_wb_hold",  wb_memread, 1);
        next_cycle();
        dm_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b_sw_wb_valid", wb_valid,   1);
        chk("b2b_sw_wb_mr",    wb_memread, 0);
        chk("b2b_sw_wb_rdata", wb_rdata,   0);
        chk("b2b_sw_wb_err",   wb_err,     0);
        chk("b2b_sw_done",     dm_req,     0);
        next_cycle();

        // async reset while in WAIT
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rstw_req_before", dm_req, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstw_req_async", dm_req, 0);
        chk("rstw_stall",     stall,  0);
        next_cycle();
        rst_n  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dm_ack = 1'b1;
        dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rstw_stray_noreq", dm_req, 0);
        next_cycle();
        dm_ack = 1'b0;
        @(negedge clk);
        chk("rstw_stray_wb",  wb_valid,   0);
        chk("rstw_stray_mr",  wb_memread, 0);
        chk("rstw_stray_rd",  wb_rdata,   0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- MEM-stage data-memory access controller. Sits between the EX/MEM pipeline register and the synchronous data memory, and feeds the WB-stage load-extension logic.
- Generates store byte strobes and replicated store data, and detects misaligned or illegal accesses.
- Runs a ready/ack handshake with a variable-latency memory, stalls the pipeline while an access is outstanding, and enforces an ack timeout.
- Registers the raw read word plus funct3 and address low bits into the MEM/WB stage for the downstream sign/zero-extension logic.

Parameters:
- ACK_TIMEOUT, 255: maximum number of cycles in WAIT without dm_ack before the access is aborted. Range 1..255; the counter is 8 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX/MEM slot holds a valid instruction
- req_read  in  1  load instruction
- req_write  in  1  store instruction
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  rs2 store data, unaligned
- stall  out  1  hold upstream pipeline stages
- dm_req  out  1  memory request, registered
- dm_we  out  4  byte write strobes; 0000 means read
- dm_addr  out  32  word address, bits [1:0] = 00
- dm_wdata  out  32  lane-aligned store data
- dm_ack  in  1  memory completes the access this cycle
- dm_rdata  in  32  read word, valid when dm_ack=1
- wb_valid  out  1  MEM/WB slot valid
- wb_memread  out  1  MEM/WB holds a completed load
- wb_rdata  out  32  raw read word
- wb_funct3  out  3  funct3 forwarded to load extension
- wb_addr_lo  out  2  req_addr[1:0] forwarded to load extension
- wb_err  out  1  access fault (misaligned, illegal or timeout)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, timeout counter=0.
  - dm_req=0, dm_we=0, dm_addr=0, dm_wdata=0.
  - All wb_* outputs = 0.
  - stall is 0 during reset.
- Operation detected: req_valid & (req_read | req_write).
- Fault conditions:
  - read & write both asserted → illegal.
  - Load funct3 not in {000, 001, 010, 100, 101} → illegal.
  - Store funct3 not in {000, 001, 010} → illegal.
  - Word access with addr[1:0] != 00 → misaligned.
  - Half access with addr[0] = 1 → misaligned.
- Store alignment:
  - SB: dm_we = 0001 << addr[1:0]; dm_wdata = byte replicated four times.
  - SH: dm_we = 0011 << (2*addr[1]); dm_wdata = half replicated twice.
  - SW: dm_we = 1111; dm_wdata = req_wdata.
  - Loads: dm_we = 0000.
- FSM states: IDLE, WAIT.
- IDLE:
  - Legal operation: stall=1 combinationally. At the clock edge, register dm_req=1, dm_addr={addr[31:2], 00}, dm_we, dm_wdata and the request metadata; clear the counter; go to WAIT.
  - Faulting operation: no memory access and stall=0. The MEM/WB register loads wb_valid=1, wb_err=1, wb_memread=0.
  - No operation: stall=0. The MEM/WB register loads wb_valid=req_valid, wb_memread=0, wb_err=0.
- WAIT:
  - stall = ~dm_ack & ~timeout_hit, where timeout_hit = (counter == ACK_TIMEOUT-1) & ~dm_ack.
  - dm_req and all dm_* outputs are held stable.
  - Counter increments each cycle without ack.
- Completion in WAIT:
  - On dm_ack: the MEM/WB register loads wb_valid=1, wb_memread=is_load, wb_rdata = is_load ? dm_rdata : 0, wb_funct3, wb_addr_lo, wb_err=0. dm_req drops and the FSM returns to IDLE at that edge.
  - On timeout_hit: same update but wb_err=1, wb_memread=0, wb_rdata=0.
- Latency:
  - Accept at cycle T; dm_req first high at T+1.
  - Ack at cycle A ≥ T+1; wb_valid high at A+1; upstream advances at the A edge.
  - Zero-wait memory gives one stall cycle per access.
- The MEM/WB register updates only when stall=0, and holds its contents while stall=1.
- Upstream must hold req_* stable while stall=1. The block latches the request metadata at acceptance and does not re-sample it.
- Back-to-back accesses: a new request in the cycle after ack is accepted normally from IDLE; there is no forced bubble.
- A dm_ack received in IDLE is ignored.
- rst_n asserted mid-access drops dm_req asynchronously. The memory aborts the access and any late ack is ignored.

Decomposition:
- Package dm_access_pkg holds:
  - funct3 localparams: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - state enum: IDLE, WAIT.
  - Width constant for the timeout counter.
- Sub-module store_align (combinational) computes dm_we, dm_wdata and the misaligned/illegal flags from funct3, addr[1:0], wdata and the read/write qualifiers.

Test Plan:
- SB, addr=0x1003, wdata=0x000000A5, ack at T+1 → dm_we=1000, dm_wdata=0xA5A5A5A5, dm_addr=0x1000, one stall cycle, wb_err=0.
- LHU, addr=0x2002, ack after 3 wait cycles, dm_rdata=0xBEEF1234 → stall high for 4 cycles, then wb_memread=1, wb_rdata=0xBEEF1234, wb_addr_lo=10, wb_funct3=101.
- LW, addr=0x0001 → no dm_req, stall=0, next cycle wb_valid=1, wb_err=1; same result for funct3=011 on a load.
- SW with ACK_TIMEOUT=4 and no ack → dm_req high for exactly 4 cycles, then dropped, wb_err=1, FSM returns to IDLE.
- Back-to-back LW 0x10 then SW 0x14, both acked immediately → dm_req high for T+1 and T+3 with a one-cycle gap; both wb slots valid in order.
- rst_n pulled low while in WAIT → dm_req=0 immediately; after release, a stray dm_ack causes no wb_valid.
